// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, default timing and frame constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_DEV,
    ST_SEND,
    ST_ACK,
    ST_RELEASE,
    ST_ABORT
  } ps2_state_e;

  localparam int PS2_FRAME_BITS       = 11;
  localparam int TIMER_W              = 20;
  localparam int DEF_INHIBIT_CYCLES   = 6000;
  localparam int DEF_START_TIMEOUT    = 750000;
  localparam int DEF_XFER_TIMEOUT     = 100000;
  localparam int DEF_FILTER_LEN       = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack;
  logic       tx_error;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_ack, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_ack, tx_error);
endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, consecutive-sample glitch filter, falling-edge strobe.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  output logic o_clk,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;
  logic             r_fall;

  // Count samples that disagree with the filtered level; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_ps2_clk};
      r_fall <= 1'b0;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_filt <= r_sync[1];
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk  = r_filt;
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked serialisation, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT,
  parameter int FILTER_LEN           = DEF_FILTER_LEN
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  ps2_host_tx_if.slave      tx,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  output logic              ps2_clk_oe,
  output logic              ps2_dat_oe
);

  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         LAST_FALL  = 4'(PS2_FRAME_BITS - 1);

  logic                   w_clk_f;
  logic                   w_fall;
  logic                   w_dat_s;
  logic                   w_load;
  logic                   w_shift_en;
  logic [1:0]             r_dat_sync;
  ps2_state_e             r_state;
  logic [PS2_FRAME_BITS-1:0] r_shift;
  logic [3:0]             r_bit_cnt;
  logic [TIMER_W-1:0]     r_timer;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_ack;
  logic                   r_error;
  logic                   r_clk_oe;
  logic                   r_dat_oe;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (CLOCK_50),
    .rst       (rst),
    .i_ps2_clk (PS2_CLK),
    .o_clk     (w_clk_f),
    .o_fall    (w_fall)
  );

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) r_dat_sync <= 2'b11;
    else     r_dat_sync <= {r_dat_sync[0], PS2_DAT};
  end

  assign w_dat_s    = r_dat_sync[1];
  assign w_load     = tx.tx_valid & r_ready;
  assign w_shift_en = w_fall & ((r_state == ST_WAIT_DEV) ||
                                ((r_state == ST_SEND) && (r_bit_cnt != LAST_FALL)));

  // Frame shifter is pure data: loaded on accept, advanced on each presenting fall.
  always_ff @(posedge CLOCK_50) begin
    if (w_load)
      r_shift <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
    else if (w_shift_en)
      r_shift <= {1'b0, r_shift[PS2_FRAME_BITS-1:1]};
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_timer   <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_ack     <= 1'b0;
      r_error   <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_load) begin
          r_state   <= ST_INHIBIT;
          r_ready   <= 1'b0;
          r_ack     <= 1'b0;
          r_bit_cnt <= '0;
          r_timer   <= '0;
          r_clk_oe  <= 1'b1;
          r_dat_oe  <= 1'b0;
        end
        ST_INHIBIT: begin
          if (r_timer == INH_LAST) begin
            r_state  <= ST_RTS;
            r_dat_oe <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RTS: begin
          r_state  <= ST_WAIT_DEV;
          r_clk_oe <= 1'b0;
          r_timer  <= '0;
        end
        ST_WAIT_DEV: begin
          if (w_fall) begin
            r_state   <= ST_SEND;
            r_dat_oe  <= ~r_shift[0];
            r_bit_cnt <= 4'd1;
            r_timer   <= '0;
          end else if (r_timer == START_LAST) begin
            r_state  <= ST_ABORT;
            r_error  <= 1'b1;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_SEND, ST_ACK, ST_RELEASE: begin
          if (r_timer == XFER_LAST) begin
            r_state  <= ST_ABORT;
            r_error  <= 1'b1;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (r_state == ST_SEND && w_fall) begin
              if (r_bit_cnt == LAST_FALL) begin
                r_state <= ST_ACK;
              end else begin
                r_dat_oe  <= ~r_shift[0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else if (r_state == ST_ACK) begin
              r_ack   <= ~w_dat_s;
              r_state <= ST_RELEASE;
            end else if (r_state == ST_RELEASE && w_clk_f && w_dat_s) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        ST_ABORT: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_ready = r_ready;
  assign tx.tx_done  = r_done;
  assign tx.tx_ack   = r_ack;
  assign tx.tx_error = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_dat_oe  = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, vector table plus timeout/reset/glitch cases.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int ST  = 2000;
  localparam int XF  = 1500;
  localparam int FL  = 8;
  localparam int HP  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch      = 1'b0;
  logic clk_oe, dat_oe;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(clk_oe | dev_clk_low | glitch);
  assign ps2_dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (ST),
    .XFER_TIMEOUT_CYCLES  (XF),
    .FILTER_LEN           (FL)
  ) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .tx         (tx_if),
    .PS2_CLK    (ps2_clk_line),
    .PS2_DAT    (ps2_dat_line),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   err_cyc  = 0;
  int   first_fall_cyc = 0;
  logic ack_at_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_if.tx_done) begin
      done_cnt++;
      ack_at_done = tx_if.tx_ack;
    end
    if (tx_if.tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         dev_ack;
    bit         glt;
    logic [9:0] frame;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks nclk bits, samples data on each rising edge.
  task automatic device(input int nclk, input bit ack, input bit glt,
                        output logic [9:0] rx, output bit ok);
    rx = '0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ps2_clk_line && !ps2_dat_line) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (20) @(negedge clk);
      for (int k = 0; k < nclk; k++) begin
        if (k == 10 && ack) dev_dat_low = 1'b1;
        if (k == 0) first_fall_cyc = cyc;
        dev_clk_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k < 10) rx[k] = ps2_dat_line;
        if (glt) begin
          repeat (15) @(negedge clk);
          glitch = 1'b1;
          repeat (2) @(negedge clk);
          glitch = 1'b0;
          repeat (HP - 17) @(negedge clk);
        end else begin
          repeat (HP) @(negedge clk);
        end
        if (k == 10) dev_dat_low = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input vec_t v);
    int d0, e0, inhib, busy;
    logic [9:0] rx;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    check("ready_idle", tx_if.tx_ready, 1'b1);
    start_tx(v.data);
    check("ready_busy", tx_if.tx_ready, 1'b0);
    inhib = 0;
    for (int i = 0; i < INH + 20; i++) begin
      if (clk_oe && !dat_oe) inhib++;
      else break;
      if (v.glt && i == 10) begin
        tx_if.tx_data  = 8'h55;
        tx_if.tx_valid = 1'b1;
      end else begin
        tx_if.tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_if.tx_valid = 1'b0;
    check("inhibit_len", inhib, INH);
    check("rts_oe", {clk_oe, dat_oe}, 2'b11);
    @(negedge clk);
    check("wait_dev_oe", {clk_oe, dat_oe}, 2'b01);
    device(11, v.dev_ack, v.glt, rx, ok);
    check("start_seen", ok, 1'b1);
    check("frame", rx, v.frame);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    check("done_pulses", done_cnt - d0, 1);
    check("ack", ack_at_done, v.exp_ack);
    check("no_error", err_cnt - e0, 0);
    @(negedge clk);
    check("ready_after", tx_if.tx_ready, 1'b1);
    check("released", {clk_oe, dat_oe}, 2'b00);
    busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (clk_oe) busy++;
    end
    check("single_frame", busy + (done_cnt - d0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, n;
    logic [9:0] rx;
    bit ok;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h3ED, 1'b1};
    vecs[1] = '{8'hF4, 1'b0, 1'b0, 10'h2F4, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 10'h300, 1'b1};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 10'h35A, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 10'h3FF, 1'b1};

    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_if.tx_ready, 1'b1);
    check("rst_flags", {tx_if.tx_done, tx_if.tx_ack, tx_if.tx_error}, 3'b000);
    check("rst_oe", {clk_oe, dat_oe}, 2'b00);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4; i++) send_frame(vecs[i]);

    // Device never clocks: start timeout
    d0 = done_cnt;
    start_tx(8'hED);
    n = 0;
    for (int i = 0; i < INH + ST + 200; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (tx_if.tx_error) break;
    end
    check("start_timeout_cycles", n, INH + 1 + ST);
    check("start_timeout_oe", {clk_oe, dat_oe}, 2'b00);
    @(negedge clk);
    check("start_timeout_ready", tx_if.tx_ready, 1'b1);
    check("start_timeout_nodone", done_cnt - d0, 0);

    // Device stops after five clocks: transfer timeout
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    device(5, 1'b0, 1'b0, rx, ok);
    check("xfer_start_seen", ok, 1'b1);
    for (int i = 0; i < XF + 200; i++) begin
      @(posedge clk);
      if (err_cnt != e0) break;
    end
    check("xfer_error_pulses", err_cnt - e0, 1);
    check_range("xfer_timeout_cycles", err_cyc - first_fall_cyc, XF + FL, XF + FL + 4);
    @(negedge clk);
    check("xfer_timeout_oe", {clk_oe, dat_oe}, 2'b00);
    check("xfer_timeout_nodone", done_cnt - d0, 0);

    // Reset mid-frame releases lines at once and aborts silently
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h00);
    device(4, 1'b0, 1'b0, rx, ok);
    check("rst_mid_dat_driven", dat_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", {clk_oe, dat_oe}, 2'b00);
    check("rst_async_ready", tx_if.tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_silent", (done_cnt - d0) + (err_cnt - e0), 0);

    send_frame(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
